// File: rtl/dtree_pkg.sv
// Shared constants, FSM state encodings and sizing helper for the decision-tree
// inference controller.
package dtree_pkg;

    localparam int DT_FEAT_W = 8;
    localparam int DT_CLS_W  = 3;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Index width for n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dtree_feat_bank.sv
// Addressed feature register file with a flat parallel read-out for the tree.
module dtree_feat_bank
    import dtree_pkg::*;
#(
    parameter int NUM_FEAT = 148,
    parameter int FEAT_W   = DT_FEAT_W,
    parameter int IDX_W    = idx_width(NUM_FEAT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [FEAT_W-1:0]          wr_data,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus
);

    for (genvar g = 0; g < NUM_FEAT; g++) begin : g_slot
        logic [FEAT_W-1:0] slot_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(g))) begin
                slot_q <= wr_data;
            end
        end

        assign feat_bus[g*FEAT_W +: FEAT_W] = slot_q;
    end

endmodule

// File: rtl/dtree_infer_ctrl.sv
// Serial feature loader, settle timer and result holder wrapped around the
// combinational decision tree.
module dtree_infer_ctrl
    import dtree_pkg::*;
#(
    parameter int NUM_FEAT   = 148,
    parameter int FEAT_W     = DT_FEAT_W,
    parameter int CLS_W      = DT_CLS_W,
    parameter int SETTLE_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEAT_W-1:0]          in_data,
    input  logic                       in_last,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLS_W-1:0]           tree_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLS_W-1:0]           out_class,
    output logic                       out_err,
    output logic [1:0]                 dbg_state
);

    // Handshakes: a beat moves on a rising edge where valid and ready are both
    // high; out_valid holds with stable data until out_ready is seen with it.
    localparam int IDX_W = idx_width(NUM_FEAT);
    localparam int CNT_W = idx_width(SETTLE_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             settled;
    logic             err_pend;
    logic             beat;
    logic             wr_en;

    assign in_ready  = (state == ST_LOAD);
    assign beat      = in_valid && in_ready;
    // Once a frame has overrun, surplus beats are swallowed without writing.
    assign wr_en     = beat && !err_pend;
    assign dbg_state = state;

    dtree_feat_bank #(
        .NUM_FEAT (NUM_FEAT),
        .FEAT_W   (FEAT_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_data  (in_data),
        .feat_bus (feat_bus)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            idx       <= '0;
            cnt       <= '0;
            settled   <= 1'b0;
            err_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        if (err_pend) begin
                            if (in_last) begin
                                state <= ST_SETTLE;
                                cnt   <= CNT_INIT;
                            end
                        end else if (in_last) begin
                            state <= ST_SETTLE;
                            cnt   <= CNT_INIT;
                            if (idx != LAST_IDX) begin
                                err_pend <= 1'b1;
                            end
                        end else if (idx == LAST_IDX) begin
                            err_pend <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    // One extra cycle after the count hits zero before sampling the tree.
                    if (settled) begin
                        settled   <= 1'b0;
                        out_valid <= 1'b1;
                        out_class <= err_pend ? '0 : tree_class;
                        out_err   <= err_pend;
                        state     <= ST_HOLD;
                    end else if (cnt == '0) begin
                        settled <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        err_pend  <= 1'b0;
                        idx       <= '0;
                        state     <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_infer_ctrl.sv
// Directed scenario bench for dtree_infer_ctrl with hand-computed expectations.
module tb_dtree_infer_ctrl;
    import dtree_pkg::*;

    localparam int NUM_FEAT = 148;
    localparam int FEAT_W   = 8;
    localparam int CLS_W    = 3;
    localparam int EXP_LAT  = 5;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [FEAT_W-1:0]          in_data;
    logic                       in_last;
    logic [NUM_FEAT*FEAT_W-1:0] feat_bus;
    logic [CLS_W-1:0]           tree_class;
    logic                       out_valid;
    logic                       out_ready;
    logic [CLS_W-1:0]           out_class;
    logic                       out_err;
    logic [1:0]                 dbg_state;

    logic [NUM_FEAT*FEAT_W-1:0] exp_bus;
    logic [7:0]                 frame_data [0:149];
    int                         cyc;
    int                         last_acc;
    int                         checks;
    int                         failures;

    dtree_infer_ctrl #(
        .NUM_FEAT   (NUM_FEAT),
        .FEAT_W     (FEAT_W),
        .CLS_W      (CLS_W),
        .SETTLE_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .feat_bus   (feat_bus),
        .tree_class (tree_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_err    (out_err),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver tasks
    task automatic send_beat(input logic [7:0] d, input logic l, output int acc, output bit ok);
        ok = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input bit gaps);
        bit ok;
        int acc;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data = 8'hFF;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            send_beat(frame_data[i], (i == last_at), acc, ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL beat_accept_timeout beat=%0d got=no_accept exp=accept", i);
                return;
            end
            last_acc = acc;
            if (i < NUM_FEAT) exp_bus[i*FEAT_W +: FEAT_W] = frame_data[i];
        end
    endtask

    task automatic wait_out(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(posedge clk);
            #1;
            if (out_valid) got = 1'b1;
        end
        lat = cyc - last_acc;
    endtask

    // Scenarios
    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_class !== 3'd0 || out_err !== 1'b0) begin
            failures++; $display("FAIL reset_out_data got=%0d/%b exp=0/0", out_class, out_err);
        end
        checks++;
        if (feat_bus !== exp_bus) begin failures++; $display("FAIL reset_feat_bus got=nonzero exp=0"); end
        checks++;
        if (dbg_state !== ST_LOAD) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_LOAD); end
    endtask

    task automatic test_good_frame;
        bit got;
        int lat;
        tree_class = 3'd5;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_FEAT; i++) frame_data[i] = 8'(i % 256);
        send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0);
        checks++;
        if (feat_bus[147*FEAT_W +: FEAT_W] !== 8'd147) begin
            failures++; $display("FAIL good_slot147 got=%0d exp=147", feat_bus[147*FEAT_W +: FEAT_W]);
        end
        wait_out(got, lat);
        checks++;
        if (!got) begin failures++; $display("FAIL good_out_valid got=timeout exp=valid"); return; end
        checks++;
        if (lat !== EXP_LAT) begin failures++; $display("FAIL good_latency got=%0d exp=%0d", lat, EXP_LAT); end
        checks++;
        if (out_class !== 3'd5 || out_err !== 1'b0) begin
            failures++; $display("FAIL good_result got=%0d/%b exp=5/0", out_class, out_err);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL good_hold_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL good_after_handshake got=v%b r%b exp=v0 r1", out_valid, in_ready);
        end
        checks++;
        if (feat_bus !== exp_bus) begin failures++; $display("FAIL good_feat_bus got=differs exp=sent_vector"); end
    endtask

    task automatic test_backpressure;
        bit got;
        int lat;
        bit stable;
        tree_class = 3'd2;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_FEAT; i++) frame_data[i] = 8'((i * 3 + 1) % 256);
        send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0);
        wait_out(got, lat);
        checks++;
        if (!got) begin failures++; $display("FAIL bp_out_valid got=timeout exp=valid"); return; end
        checks++;
        if (out_class !== 3'd2 || out_err !== 1'b0) begin
            failures++; $display("FAIL bp_result got=%0d/%b exp=2/0", out_class, out_err);
        end
        in_valid = 1'b1;
        in_data = 8'hEE;
        in_last = 1'b1;
        tree_class = 3'd7;
        stable = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 3'd2 || out_err !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin failures++; $display("FAIL bp_hold_stable got=changed exp=stable"); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (feat_bus !== exp_bus || dbg_state !== ST_LOAD) begin
            failures++; $display("FAIL bp_no_accept_in_hold got=slot0 %0d state %0d exp=slot0 1 state 0",
                                 feat_bus[7:0], dbg_state);
        end
    endtask

    task automatic test_early_last;
        bit got;
        int lat;
        tree_class = 3'd6;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) frame_data[i] = 8'(100 + i);
        send_frame(10, 9, 1'b0);
        wait_out(got, lat);
        checks++;
        if (!got) begin failures++; $display("FAIL early_out_valid got=timeout exp=valid"); return; end
        checks++;
        if (out_class !== 3'd0 || out_err !== 1'b1) begin
            failures++; $display("FAIL early_result got=%0d/%b exp=0/1", out_class, out_err);
        end
        checks++;
        if (lat !== EXP_LAT) begin failures++; $display("FAIL early_latency got=%0d exp=%0d", lat, EXP_LAT); end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_FEAT; i++) frame_data[i] = 8'(255 - i);
        send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0);
        wait_out(got, lat);
        checks++;
        if (!got) begin failures++; $display("FAIL early_next_valid got=timeout exp=valid"); return; end
        checks++;
        if (out_class !== 3'd6 || out_err !== 1'b0) begin
            failures++; $display("FAIL early_next_result got=%0d/%b exp=6/0", out_class, out_err);
        end
        checks++;
        if (feat_bus[7:0] !== 8'd255 || feat_bus !== exp_bus) begin
            failures++; $display("FAIL early_next_feat_bus got=slot0 %0d exp=slot0 255", feat_bus[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_missing_last;
        bit got;
        int lat;
        tree_class = 3'd4;
        out_ready = 1'b1;
        for (int i = 0; i < 150; i++) frame_data[i] = 8'((i * 7) % 256);
        send_frame(150, 149, 1'b0);
        checks++;
        if (feat_bus[147*FEAT_W +: FEAT_W] !== 8'd5) begin
            failures++; $display("FAIL missing_slot147 got=%0d exp=5", feat_bus[147*FEAT_W +: FEAT_W]);
        end
        wait_out(got, lat);
        checks++;
        if (!got) begin failures++; $display("FAIL missing_out_valid got=timeout exp=valid"); return; end
        checks++;
        if (out_class !== 3'd0 || out_err !== 1'b1) begin
            failures++; $display("FAIL missing_result got=%0d/%b exp=0/1", out_class, out_err);
        end
        checks++;
        if (feat_bus !== exp_bus) begin failures++; $display("FAIL missing_feat_bus got=differs exp=first_148"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit got;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_FEAT; i++) frame_data[i] = 8'((i + 17) % 256);
        send_frame(60, -1, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_bus = '0;
        checks++;
        if (feat_bus !== exp_bus || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_async got=v%b r%b bus_zero=%b exp=v0 r1 bus_zero=1",
                                 out_valid, in_ready, (feat_bus == '0));
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        tree_class = 3'd3;
        out_ready = 1'b0;
        send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0);
        wait_out(got, lat);
        #2 rst = 1'b1;
        #1;
        exp_bus = '0;
        checks++;
        if (!got || out_valid !== 1'b0 || dbg_state !== ST_LOAD) begin
            failures++; $display("FAIL rst_hold_async got=seen%b v%b st%0d exp=seen1 v0 st0", got, out_valid, dbg_state);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        tree_class = 3'd1;
        out_ready = 1'b1;
        send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0);
        wait_out(got, lat);
        checks++;
        if (!got || out_class !== 3'd1 || out_err !== 1'b0 || lat !== EXP_LAT) begin
            failures++; $display("FAIL rst_next_frame got=seen%b %0d/%b lat%0d exp=seen1 1/0 lat5",
                                 got, out_class, out_err, lat);
        end
        checks++;
        if (feat_bus !== exp_bus) begin failures++; $display("FAIL rst_next_feat_bus got=differs exp=sent_vector"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_valid_gaps;
        bit got;
        int lat;
        tree_class = 3'd7;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_FEAT; i++) frame_data[i] = 8'(i) ^ 8'h5A;
        send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b1);
        wait_out(got, lat);
        checks++;
        if (!got || out_class !== 3'd7 || out_err !== 1'b0) begin
            failures++; $display("FAIL gaps_result got=seen%b %0d/%b exp=seen1 7/0", got, out_class, out_err);
        end
        checks++;
        if (feat_bus !== exp_bus) begin failures++; $display("FAIL gaps_feat_bus got=differs exp=sent_vector"); end
        @(posedge clk);
        #1;
    endtask

    // Reset, scenario sequence and report
    initial begin
        checks = 0;
        failures = 0;
        last_acc = 0;
        exp_bus = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        tree_class = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_valid_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtree_infer_ctrl.md
Name: dtree_infer_ctrl

Overview:
- Sequencing controller for the combinational decision-tree classifier.
- Features arrive serially, one 8-bit feature per beat, over a valid/ready stream. This keeps pin count low on printed substrates.
- The block assembles the features into a parallel feature bus for the tree and waits a programmable settle time for the tree's logic to resolve.
- It then captures the 3-bit class and presents it on an output valid/ready handshake. It sits between the sensor/host interface and the tree instance.

Parameters:
- NUM_FEAT, 148, number of 8-bit features the tree consumes.
- FEAT_W, 8, feature width in bits.
- CLS_W, 3, class output width in bits.
- SETTLE_CYC, 4, cycles allowed for the combinational tree to resolve after the last feature loads (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  controller accepts a feature beat.
- in_data  in  FEAT_W  feature value, sent in feature-index order 0..NUM_FEAT-1.
- in_last  in  1  marks the final beat of a frame.
- feat_bus  out  NUM_FEAT*FEAT_W  parallel features to the tree; feature i occupies bits [i*FEAT_W +: FEAT_W].
- tree_class  in  CLS_W  class result from the tree.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  CLS_W  captured class.
- out_err  out  1  framing error flag, qualified by out_valid.

Behaviour:
- Reset is asynchronous and active-high and applies to the whole block.
- Reset values:
  - state = LOAD, idx = 0, settle counter = 0.
  - feat_bus = 0, in_ready = 1.
  - out_valid = 0, out_class = 0, out_err = 0.
- A beat transfers when in_valid and in_ready are both high at a rising clk edge.
- State machine, states LOAD, SETTLE, HOLD:
  - LOAD: in_ready = 1. Each transferred beat writes in_data to feature slot idx, then idx increments.
    - Beat with idx = NUM_FEAT-1 and in_last = 1: good frame. Go to SETTLE and load the counter with SETTLE_CYC-1.
    - Beat with in_last = 1 and idx < NUM_FEAT-1: early last. Set err_pend and go to SETTLE.
    - Beat with idx = NUM_FEAT-1 and in_last = 0: missing last. Set err_pend. Keep discarding further beats (no write, idx held) until a beat with in_last = 1, then go to SETTLE.
  - SETTLE: in_ready = 0. The counter decrements each cycle. When it reaches 0, on the next edge:
    - out_class <= tree_class (or 0 if err_pend);
    - out_err <= err_pend;
    - out_valid <= 1;
    - go to HOLD.
  - HOLD: in_ready = 0. out_valid stays high and out_class and out_err stay stable until out_valid and out_ready are both high. On that handshake edge:
    - out_valid <= 0, err_pend <= 0, idx <= 0;
    - go to LOAD.
- Latency: out_valid rises exactly SETTLE_CYC+1 cycles after the edge that accepts the last beat. With SETTLE_CYC = 1, that is 2 cycles.
- feat_bus holds its values from frame to frame. Slots are overwritten only by new beats; there is no clearing between frames.
- feat_bus does not change during SETTLE or HOLD, so tree_class is stable when sampled.
- Throughput: at most one frame per NUM_FEAT + SETTLE_CYC + 2 cycles. in_ready never overlaps HOLD; there is no result double-buffering.
- out_ready high outside HOLD has no effect.
- Reset mid-frame or in HOLD: the pending result is lost, out_valid drops immediately, and the next frame starts at index 0.
- idx width is clog2(NUM_FEAT). idx never wraps. In the missing-last case idx is held, and any value outside 0..NUM_FEAT-1 is unreachable.

Decomposition:
- Shared package dtree_pkg holds:
  - state enum {LOAD, SETTLE, HOLD};
  - FEAT_W and CLS_W constants;
  - a function computing idx width from NUM_FEAT.
- One natural sub-module: dtree_feat_bank. It is the addressed register file with write enable, write index and data, and a flat parallel output.
- The FSM, settle counter and output register stay in dtree_infer_ctrl.

Test Plan:
- Good frame, NUM_FEAT = 148, SETTLE_CYC = 4: send bytes i%256 with last on beat 147 and drive tree_class = 3'd5 with out_ready held high. Expected: feat_bus slot 147 = 147; out_valid rises 5 cycles after the last accept with out_class = 5 and out_err = 0; in_ready returns the cycle after the handshake.
- Backpressure: hold out_ready = 0 for 10 cycles in HOLD while in_valid stays high. Expected: in_ready = 0 throughout; out_class and out_valid stable; the frame is accepted only after out_ready goes to 1.
- Early last: in_last on beat 9 (idx 9). Expected: out_valid with out_err = 1 and out_class = 0; the next frame starts at idx 0 and yields out_err = 0.
- Missing last: send 150 beats with in_last only on the 150th. Expected: beats 148 and 149 do not modify slot 147; out_err = 1.
- Reset mid-frame: assert rst after 60 beats. Expected: feat_bus = 0 and out_valid = 0 asynchronously; a subsequent full frame classifies correctly with out_err = 0.
- In-valid gaps: toggle in_valid randomly during a frame. Expected: only handshaked beats are written; the final feat_bus equals the sent vector.
